// File: rtl/execute_stage.sv
// Y86-64 execute stage: combinational ALU and cnd predicate, plus the
// architectural condition-code register that OPq updates on the clock.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valC,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [2:0]  cf_in,
  output logic [63:0] valE,
  output logic        cnd,
  output logic [2:0]  cf_out
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  logic       zf_new;
  logic       sf_new;
  logic       of_new;
  logic       cc_load;
  logic       zf_in;
  logic       sf_in;
  logic       of_in;

  always_comb begin
    valE = 64'd0;
    unique case (icode)
      I_HALT, I_NOP:     valE = 64'd0;
      I_RRMOVQ:          valE = valA;
      I_IRMOVQ:          valE = valC;
      I_RMMOVQ, I_MRMOVQ: valE = valB + valC;
      I_OPQ: begin
        case (ifun)
          A_ADD:   valE = valB + valA;
          A_SUB:   valE = valB - valA;
          A_AND:   valE = valB & valA;
          A_XOR:   valE = valB ^ valA;
          default: valE = 64'd0;
        endcase
      end
      I_JXX:             valE = 64'd0;
      I_CALL, I_PUSHQ:   valE = valB - 64'd8;
      I_RET, I_POPQ:     valE = valB + 64'd8;
      default:           valE = 64'd0;
    endcase
  end

  // Flags derived from the ALU result; only meaningful when cc_load is high.
  always_comb begin
    zf_new = (valE == 64'd0);
    sf_new = valE[63];
    of_new = 1'b0;
    case (ifun)
      A_ADD:   of_new = (valA[63] == valB[63]) && (valE[63] != valB[63]);
      A_SUB:   of_new = (valA[63] != valB[63]) && (valE[63] != valB[63]);
      default: of_new = 1'b0;
    endcase
  end

  assign cc_load = (icode == I_OPQ) && (ifun <= A_XOR);

  assign zf_in = cf_in[2];
  assign sf_in = cf_in[1];
  assign of_in = cf_in[0];

  always_comb begin
    cnd = 1'b0;
    if (icode == I_RRMOVQ || icode == I_JXX) begin
      case (ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (sf_in ^ of_in) | zf_in;
        4'h2:    cnd = sf_in ^ of_in;
        4'h3:    cnd = zf_in;
        4'h4:    cnd = ~zf_in;
        4'h5:    cnd = ~(sf_in ^ of_in);
        4'h6:    cnd = ~(sf_in ^ of_in) & ~zf_in;
        default: cnd = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cf_out <= 3'b000;
    else if (cc_load)
      cf_out <= {zf_new, sf_new, of_new};
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: hand-computed ALU, cnd and
// condition-code register values, checked with immediate assertions.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valC;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [2:0]  cf_in;
  logic [63:0] valE;
  logic        cnd;
  logic [2:0]  cf_out;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk    (clk),
    .rst    (rst),
    .icode  (icode),
    .ifun   (ifun),
    .valC   (valC),
    .valA   (valA),
    .valB   (valB),
    .cf_in  (cf_in),
    .valE   (valE),
    .cnd    (cnd),
    .cf_out (cf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply a new input set mid-low-phase and let combinational outputs settle.
  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] c, input logic [63:0] a,
                       input logic [63:0] b, input logic [2:0] f);
    @(negedge clk);
    icode = ic; ifun = fn; valC = c; valA = a; valB = b; cf_in = f;
    #1;
  endtask

  task automatic edge_then_settle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    icode = 4'h0; ifun = 4'h0; valC = '0; valA = '0; valB = '0; cf_in = 3'b000;
    #1;
    chk("reset_cf", {61'd0, cf_out}, 64'd0);
    chk("halt_valE", valE, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // subq 5-5 -> zero
    drive(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 3'b000);
    chk("subq_zero_valE", valE, 64'd0);
    chk("cf_hold_before_edge", {61'd0, cf_out}, 64'd0);
    edge_then_settle();
    chk("subq_zero_cf", {61'd0, cf_out}, 64'd4);

    // addq positive overflow, then async reset mid-cycle
    drive(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 3'b000);
    chk("addq_ovf_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    edge_then_settle();
    chk("addq_ovf_cf", {61'd0, cf_out}, 64'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_cf", {61'd0, cf_out}, 64'd0);
    chk("valE_indep_rst", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    #2;
    rst = 1'b0;

    // subq 3-5 -> -2, then invalid OPq must not touch flags
    drive(4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 3'b000);
    chk("subq_neg_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    edge_then_settle();
    chk("subq_neg_cf", {61'd0, cf_out}, 64'd2);
    drive(4'h6, 4'h5, 64'd0, 64'd5, 64'd3, 3'b000);
    chk("opq_bad_ifun_valE", valE, 64'd0);
    edge_then_settle();
    chk("opq_bad_ifun_cf_hold", {61'd0, cf_out}, 64'd2);
    drive(4'hC, 4'h1, 64'd0, 64'd5, 64'd5, 3'b111);
    chk("invalid_icode_valE", valE, 64'd0);
    chk("invalid_icode_cnd", {63'd0, cnd}, 64'd0);
    edge_then_settle();
    chk("invalid_icode_cf_hold", {61'd0, cf_out}, 64'd2);

    // subq negative overflow: 0x8000..0 - 1
    drive(4'h6, 4'h1, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 3'b000);
    chk("subq_ovf_valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
    edge_then_settle();
    chk("subq_ovf_cf", {61'd0, cf_out}, 64'd1);

    // andq / xorq
    drive(4'h6, 4'h2, 64'd0, 64'h3C, 64'hF0, 3'b000);
    chk("andq_valE", valE, 64'h30);
    edge_then_settle();
    chk("andq_cf", {61'd0, cf_out}, 64'd0);
    drive(4'h6, 4'h2, 64'd0, 64'h0F, 64'hF0, 3'b000);
    chk("andq_zero_valE", valE, 64'd0);
    edge_then_settle();
    chk("andq_zero_cf", {61'd0, cf_out}, 64'd4);
    drive(4'h6, 4'h3, 64'd0, 64'hFFFF_FFFF_FFFF_FF3C, 64'hF0, 3'b000);
    chk("xorq_valE", valE, 64'hFFFF_FFFF_FFFF_FFCC);
    edge_then_settle();
    chk("xorq_cf", {61'd0, cf_out}, 64'd2);

    // jXX predicate with SF=1, OF=0, ZF=0
    drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 3'b010);
    chk("jl_cnd", {63'd0, cnd}, 64'd1);
    chk("jxx_valE", valE, 64'd0);
    drive(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 3'b010);
    chk("jge_cnd", {63'd0, cnd}, 64'd0);
    drive(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 3'b010);
    chk("jg_cnd", {63'd0, cnd}, 64'd0);
    drive(4'h7, 4'h0, 64'd0, 64'd0, 64'd0, 3'b010);
    chk("jmp_cnd", {63'd0, cnd}, 64'd1);
    drive(4'h7, 4'h8, 64'd0, 64'd0, 64'd0, 3'b010);
    chk("j_bad_ifun_cnd", {63'd0, cnd}, 64'd0);
    drive(4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 3'b010);
    chk("jle_cnd", {63'd0, cnd}, 64'd1);
    drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 3'b010);
    chk("je_cnd", {63'd0, cnd}, 64'd0);
    drive(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 3'b010);
    chk("jne_cnd", {63'd0, cnd}, 64'd1);
    drive(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 3'b000);
    chk("jg_pos_cnd", {63'd0, cnd}, 64'd1);
    drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 3'b011);
    chk("jl_sf_of_cnd", {63'd0, cnd}, 64'd0);
    edge_then_settle();
    chk("jxx_cf_hold", {61'd0, cf_out}, 64'd2);

    // cmove / irmovq
    drive(4'h2, 4'h3, 64'd0, 64'd9, 64'd0, 3'b100);
    chk("cmove_valE", valE, 64'd9);
    chk("cmove_cnd", {63'd0, cnd}, 64'd1);
    drive(4'h3, 4'h0, 64'h100, 64'd9, 64'd0, 3'b100);
    chk("irmovq_valE", valE, 64'h100);
    chk("irmovq_cnd", {63'd0, cnd}, 64'd0);
    drive(4'h1, 4'h0, 64'h100, 64'd9, 64'd7, 3'b100);
    chk("nop_valE", valE, 64'd0);

    // stack and memory addressing
    drive(4'h8, 4'h0, 64'h10, 64'd0, 64'h200, 3'b000);
    chk("call_valE", valE, 64'h1F8);
    drive(4'hA, 4'h0, 64'h10, 64'd0, 64'h200, 3'b000);
    chk("pushq_valE", valE, 64'h1F8);
    drive(4'h9, 4'h0, 64'h10, 64'd0, 64'h200, 3'b000);
    chk("ret_valE", valE, 64'h208);
    drive(4'hB, 4'h0, 64'h10, 64'd0, 64'h200, 3'b000);
    chk("popq_valE", valE, 64'h208);
    drive(4'h4, 4'h0, 64'h10, 64'd0, 64'h200, 3'b000);
    chk("rmmovq_valE", valE, 64'h210);
    drive(4'h5, 4'h0, 64'h10, 64'd0, 64'h200, 3'b000);
    chk("mrmovq_valE", valE, 64'h210);
    drive(4'hA, 4'h0, 64'h10, 64'd0, 64'd0, 3'b000);
    chk("pushq_wrap_valE", valE, 64'hFFFF_FFFF_FFFF_FFF8);
    edge_then_settle();
    chk("nonop_cf_hold", {61'd0, cf_out}, 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
